// File: rtl/sa_pkg.sv
// Shared sizing for the 3x3 weight-stationary systolic convolution array.
package sa_pkg;
  localparam int DATA_W = 8;
  localparam int N      = 3;

  // Column c output is delayed so that every column lines up with the last one.
  function automatic int deskew_depth(input int n, input int col);
    return 2 * (n - 1 - col);
  endfunction
endpackage

// File: rtl/sa_pe.sv
// One processing element: registered weight, subject pass-through and
// multiply-accumulate partial sum (all unsigned, wrapping at W bits).
module sa_pe #(
  parameter int W = sa_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] weight_in,
  input  logic [W-1:0] sub_in,
  input  logic [W-1:0] psum_in,
  output logic [W-1:0] sub_out,
  output logic [W-1:0] psum_out
);
  logic [W-1:0] weight_q, weight_d;
  logic [W-1:0] sub_q, sub_d;
  logic [W-1:0] psum_q, psum_d;

  // The MAC uses the subject arriving this cycle, not the one already stored.
  always_comb begin
    weight_d = weight_in;
    sub_d    = sub_in;
    psum_d   = psum_in + weight_q * sub_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weight_q <= '0;
      sub_q    <= '0;
      psum_q   <= '0;
    end else begin
      weight_q <= weight_d;
      sub_q    <= sub_d;
      psum_q   <= psum_d;
    end
  end

  assign sub_out  = sub_q;
  assign psum_out = psum_q;
endmodule

// File: rtl/systolic_array.sv
// 3x3 systolic convolution: subjects flow right, partial sums flow down,
// column outputs are deskewed and summed into a registered result.
module systolic_array #(
  parameter int DATA_W = sa_pkg::DATA_W,
  parameter int N      = sa_pkg::N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] weight_in_1_1,
  input  logic [DATA_W-1:0] weight_in_1_2,
  input  logic [DATA_W-1:0] weight_in_1_3,
  input  logic [DATA_W-1:0] weight_in_2_1,
  input  logic [DATA_W-1:0] weight_in_2_2,
  input  logic [DATA_W-1:0] weight_in_2_3,
  input  logic [DATA_W-1:0] weight_in_3_1,
  input  logic [DATA_W-1:0] weight_in_3_2,
  input  logic [DATA_W-1:0] weight_in_3_3,
  input  logic [DATA_W-1:0] subject_in_1,
  input  logic [DATA_W-1:0] subject_in_2,
  input  logic [DATA_W-1:0] subject_in_3,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] weight     [N][N];
  logic [DATA_W-1:0] subject    [N];
  logic [DATA_W-1:0] sub_in_w   [N][N];
  logic [DATA_W-1:0] psum_in_w  [N][N];
  logic [DATA_W-1:0] sub_chain  [N][N];
  logic [DATA_W-1:0] psum_chain [N][N];
  logic [DATA_W-1:0] col_out    [N];
  logic [DATA_W-1:0] result_d, result_q;

  assign weight[0][0] = weight_in_1_1;
  assign weight[0][1] = weight_in_1_2;
  assign weight[0][2] = weight_in_1_3;
  assign weight[1][0] = weight_in_2_1;
  assign weight[1][1] = weight_in_2_2;
  assign weight[1][2] = weight_in_2_3;
  assign weight[2][0] = weight_in_3_1;
  assign weight[2][1] = weight_in_3_2;
  assign weight[2][2] = weight_in_3_3;
  assign subject[0]   = subject_in_1;
  assign subject[1]   = subject_in_2;
  assign subject[2]   = subject_in_3;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      if (c == 0) begin : g_sub_edge
        assign sub_in_w[r][c] = subject[r];
      end else begin : g_sub_pass
        assign sub_in_w[r][c] = sub_chain[r][c-1];
      end

      if (r == 0) begin : g_psum_edge
        assign psum_in_w[r][c] = '0;
      end else begin : g_psum_pass
        assign psum_in_w[r][c] = psum_chain[r-1][c];
      end

      sa_pe #(.W(DATA_W)) u_pe (
        .clk      (clk),
        .reset    (reset),
        .weight_in(weight[r][c]),
        .sub_in   (sub_in_w[r][c]),
        .psum_in  (psum_in_w[r][c]),
        .sub_out  (sub_chain[r][c]),
        .psum_out (psum_chain[r][c])
      );
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_deskew
    localparam int DEPTH = sa_pkg::deskew_depth(N, c);
    if (DEPTH == 0) begin : g_direct
      assign col_out[c] = psum_chain[N-1][c];
    end else begin : g_dly
      logic [DATA_W-1:0] dly_q [DEPTH];
      logic [DATA_W-1:0] dly_d [DEPTH];

      always_comb begin
        dly_d[0] = psum_chain[N-1][c];
        for (int i = 1; i < DEPTH; i++) dly_d[i] = dly_q[i-1];
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign col_out[c] = dly_q[DEPTH-1];
    end
  end

  always_comb begin
    result_d = '0;
    for (int c = 0; c < N; c++) result_d = result_d + col_out[c];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result = result_q;
endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: a history-window model checked every
// cycle, plus hand-computed expectations for impulses, saturation and reset.
module tb_systolic_array;
  localparam int L = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] w [3][3];
  logic [7:0] s [3];
  logic [7:0] result;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int sh [3][8];
  int x  [3][L];

  logic [7:0] t_row1 [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd13, 8'd0};
  logic [7:0] t_row3 [9] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd52, 8'd51, 8'd0, 8'd0, 8'd0};

  always #5 clk = ~clk;

  systolic_array dut (
    .clk          (clk),
    .reset        (reset),
    .weight_in_1_1(w[0][0]),
    .weight_in_1_2(w[0][1]),
    .weight_in_1_3(w[0][2]),
    .weight_in_2_1(w[1][0]),
    .weight_in_2_2(w[1][1]),
    .weight_in_2_3(w[1][2]),
    .weight_in_3_1(w[2][0]),
    .weight_in_3_2(w[2][1]),
    .weight_in_3_3(w[2][2]),
    .subject_in_1 (s[0]),
    .subject_in_2 (s[1]),
    .subject_in_3 (s[2]),
    .result       (result)
  );

  // sh[r][k] holds the subject of row r sampled k edges ago; reset wipes history.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 8; k++) sh[r][k] = 0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int k = 7; k > 0; k--) sh[r][k] = sh[r][k-1];
        sh[r][0] = int'(s[r]);
      end
    end
  end

  function automatic logic [7:0] model_result();
    int acc;
    acc = 0;
    if (!reset) return 8'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc += int'(w[r][c]) * sh[r][7 - r - c];
    return acc[7:0];
  endfunction

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: result=%0d required=%0d at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) check_output("model", result, model_result());

  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    s[0] = a;
    s[1] = b;
    s[2] = c;
  endtask

  task automatic set_default_weights();
    w[0][0] = 8'd13; w[0][1] = 8'd2;  w[0][2] = 8'd3;
    w[1][0] = 8'd2;  w[1][1] = 8'd1;  w[1][2] = 8'd50;
    w[2][0] = 8'd51; w[2][1] = 8'd52; w[2][2] = 8'd1;
  endtask

  function automatic int xv(input int r, input int t);
    if (t < 0 || t >= L) return 0;
    return x[r][t];
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] win;
    int acc;
    reset = 1'b1;
    apply_stimulus(8'd0, 8'd0, 8'd0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = 8'd0;
    #1 reset = 1'b0;

    // Held in reset with garbage on every input; result must stay 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply_stimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) w[r][c] = 8'($urandom_range(0, 255));
      check_output("in_reset_zero", result, 8'd0);
    end
    @(negedge clk);
    apply_stimulus(8'd0, 8'd0, 8'd0);
    set_default_weights();
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("post_release_zero", result, 8'd0);
    end

    // Impulse on row 1.
    apply_stimulus(8'd1, 8'd0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) apply_stimulus(8'd0, 8'd0, 8'd0);
      check_output("impulse_row1", result, t_row1[i]);
    end

    // Impulse on row 3.
    apply_stimulus(8'd0, 8'd0, 8'd1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) apply_stimulus(8'd0, 8'd0, 8'd0);
      check_output("impulse_row3", result, t_row3[i]);
    end

    // All ones settle to the weight sum, all 255s wrap.
    apply_stimulus(8'd1, 8'd1, 8'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 7) check_output("all_ones", result, 8'd175);
    end
    apply_stimulus(8'd255, 8'd255, 8'd255);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 7) check_output("all_255_wrap", result, 8'd81);
    end

    // Mid-stream asynchronous reset, then no stale sums after release.
    apply_stimulus(8'd1, 8'd1, 8'd1);
    repeat (8) @(negedge clk);
    check_output("pre_reset_ones", result, 8'd175);
    #2 reset = 1'b0;
    #1 check_output("async_reset", result, 8'd0);
    apply_stimulus(8'd0, 8'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_output("no_stale", result, 8'd0);
    end

    // Unit weights with a random skewed stream: 3x3 sliding-window sums.
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = 8'd1;
    for (int r = 0; r < 3; r++)
      for (int t = 0; t < L; t++) x[r][t] = $urandom_range(0, 255);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < L + 12; k++) begin
      @(negedge clk);
      acc = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) acc += xv(r, k - 8 + c);
      win = acc[7:0];
      check_output("window_sum", result, win);
      apply_stimulus(8'(xv(0, k)), 8'(xv(1, k - 1)), 8'(xv(2, k - 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/systolic_array.md
SYSTOLIC_ARRAY -- requirements
Module: systolic_array

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of weights, subjects, internal sums and result.
REQ-002 Parameter N, default 3, SHALL set the array dimension (N x N PEs); only N=3 is required.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all registers.
REQ-005 reset  input  1  asynchronous active-low reset; 0 clears all state.
REQ-006 weight_in_r_c (r,c = 1..3)  input  8 each  stationary kernel weight for the PE at row r, column c.
REQ-007 subject_in_r (r = 1..3)  input  8 each  subject (activation) stream for row r; row r is pre-skewed by r-1 cycles.
REQ-008 result  output  8  registered convolution output, one value per cycle.

Function
REQ-009 Let s_r(n) be subject_in_r sampled at rising edge n, and w(r,c) = weight_in_r_c.
REQ-010 After edge n, result SHALL equal the sum over r,c = 1..3 of w(r,c)*s_r(n-9+r+c), taken modulo 256.
REQ-011 Fixed latency: the newest term (r=c=3) SHALL be sampled 3 edges before the result shows it; the oldest term (r=c=1) SHALL be sampled 7 edges before.
REQ-012 All arithmetic SHALL be unsigned; products and sums SHALL be truncated to 8 bits (wrap-around); no saturation and no overflow flag.
REQ-013 Weights SHALL be registered into the PEs every cycle.
REQ-014 Weights SHALL be held constant by the user while a stream runs; weight changes take effect at the next edge with no flush.
REQ-015 The block SHALL have no handshake or valid signals: it processes every cycle.
REQ-016 Zero subject inputs SHALL contribute zero; the user pads stream start and end with zeros.
REQ-017 Subject values SHALL move one PE to the right per cycle along their row.
REQ-018 Partial sums SHALL move one PE down per cycle along each column.
REQ-019 Column outputs SHALL be deskewed by delays of 4, 2 and 0 cycles for columns 1, 2 and 3, then summed into the result register.

Reset
REQ-020 While reset=0, every register (subject pipes, weight registers, partial sums, deskew delays, result) SHALL be 0 and result SHALL read 0.
REQ-021 Reset assertion SHALL take effect immediately, without waiting for a clock edge.
REQ-022 After reset release, result SHALL stay 0 until nonzero subjects propagate through the pipeline as defined in REQ-010.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight data; after release, no stale partial sum SHALL reappear.

Structure
REQ-024 DATA_W and N SHALL live in a shared package, sa_pkg.
REQ-025 A single sub-module, sa_pe, SHALL hold one weight, one subject pass-through register and one multiply-accumulate partial-sum register; it SHALL be instantiated 9 times.
REQ-026 The top level SHALL contain only the PE grid, the deskew delay lines, the final 3-input adder and the result register.

Verification
Weights for all scenarios unless stated: w11=13, w12=2, w13=3, w21=2, w22=1, w23=50, w31=51, w32=52, w33=1.
REQ-027 Reset=0 with random inputs, then release with subjects 0 -> result = 0 on every cycle.
REQ-028 s_1 = 1 at edge n0 only, all other subjects 0 -> result = 3 after n0+5, 2 after n0+6, 13 after n0+7, 0 at all other times.
REQ-029 s_3 = 1 at edge n0 only -> result = 1 after n0+3, 52 after n0+4, 51 after n0+5, 0 otherwise.
REQ-030 All subjects held at 1 -> result settles to 175 from edge 7 after the first 1 onward; all subjects held at 255 -> result = 81 (wrap-around).
REQ-031 Stream of all 1s, then reset=0 between edges -> result = 0 at once, without a clock edge; after release with inputs 0 -> result stays 0 (no stale sums).
REQ-032 All weights = 1 and a random skewed 3-row stream -> result matches the modulo-256 3x3 sliding-window sum from a software reference model, cycle for cycle.
